// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, frame
// geometry defaults and the idle line level.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int   UART_DBIT    = 8;
  localparam int   UART_OVS     = 16;
  localparam int   UART_SB_TICK = 16;
  localparam logic TX_IDLE      = 1'b1;

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter. The winner is combinational; the last-grant
// register only advances on cycles where the grant is actually taken.
module uart_rr_arb2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_vld,
  output logic o_sel
);

  // 1 = B was served last, so A holds priority out of reset
  logic r_last_b;

  always_comb begin
    o_vld = i_req_a | i_req_b;
    if (i_req_a && i_req_b) o_sel = ~r_last_b;
    else                    o_sel = i_req_b;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            r_last_b <= 1'b1;
    else if (i_en && o_vld)  r_last_b <= o_sel;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// UART transmitter shared by two requesters: round-robin grant, then a
// start / DBIT data / stop frame timed by the oversampled rate tick.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int DBIT    = UART_DBIT,
  parameter int OVS     = UART_OVS,
  parameter int SB_TICK = UART_SB_TICK
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            rate,
  input  logic            req_a,
  input  logic [DBIT-1:0] data_a,
  output logic            ack_a,
  input  logic            req_b,
  input  logic [DBIT-1:0] data_b,
  output logic            ack_b,
  output logic            tx,
  output logic            busy,
  output logic            owner
);

  localparam int TMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = $clog2(DBIT + 1);

  uart_state_t     r_state, w_state_nxt;
  logic [TW-1:0]   r_tick, w_tick_nxt;
  logic [BW-1:0]   r_bit, w_bit_nxt;
  logic [DBIT-1:0] r_shift, w_shift_nxt;
  logic            r_tx, r_busy, r_ack_a, r_ack_b, r_owner;
  logic            w_tx_nxt, w_busy_nxt, w_ack_a_nxt, w_ack_b_nxt, w_owner_nxt;
  logic            w_gnt_en, w_gnt_vld, w_gnt_sel;
  logic            w_ovs_done, w_sb_done;

  assign w_gnt_en   = (r_state == ST_IDLE);
  assign w_ovs_done = rate && (r_tick == TW'(OVS - 1));
  assign w_sb_done  = rate && (r_tick == TW'(SB_TICK - 1));

  uart_rr_arb2 u_arb (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_en    (w_gnt_en),
    .i_req_a (req_a),
    .i_req_b (req_b),
    .o_vld   (w_gnt_vld),
    .o_sel   (w_gnt_sel)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    case (r_state)
      ST_IDLE: begin
        w_tick_nxt = '0;
        w_bit_nxt  = '0;
        if (w_gnt_vld) begin
          w_state_nxt = ST_START;
          w_shift_nxt = w_gnt_sel ? data_b : data_a;
        end
      end
      ST_START: begin
        if (w_ovs_done) begin
          w_tick_nxt  = '0;
          w_state_nxt = ST_DATA;
        end else if (rate) begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end
      ST_DATA: begin
        if (w_ovs_done) begin
          w_tick_nxt  = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_bit == BW'(DBIT - 1)) begin
            w_bit_nxt   = '0;
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end else if (rate) begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end
      ST_STOP: begin
        if (w_sb_done) begin
          w_tick_nxt  = '0;
          w_state_nxt = ST_IDLE;
        end else if (rate) begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in registers
  always_comb begin
    case (w_state_nxt)
      ST_START: w_tx_nxt = 1'b0;
      ST_DATA:  w_tx_nxt = w_shift_nxt[0];
      default:  w_tx_nxt = TX_IDLE;
    endcase
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_ack_a_nxt = w_gnt_en && w_gnt_vld && !w_gnt_sel;
    w_ack_b_nxt = w_gnt_en && w_gnt_vld && w_gnt_sel;
    w_owner_nxt = (w_gnt_en && w_gnt_vld) ? w_gnt_sel : r_owner;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tx    <= TX_IDLE;
      r_busy  <= 1'b0;
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      r_owner <= 1'b0;
    end else begin
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_ack_a <= w_ack_a_nxt;
      r_ack_b <= w_ack_b_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  assign tx    = r_tx;
  assign busy  = r_busy;
  assign ack_a = r_ack_a;
  assign ack_b = r_ack_b;
  assign owner = r_owner;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: frame-level reference model checked every
// cycle, plus directed scenarios with hand-computed timings and orderings.
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int DBIT    = 8;
  localparam int OVS     = 16;
  localparam int SB_TICK = 16;
  localparam int FRAME   = (1 + DBIT) * OVS + SB_TICK;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            rate = 1'b0;
  logic            req_a = 1'b0, req_b = 1'b0;
  logic [DBIT-1:0] data_a = '0, data_b = '0;
  logic            ack_a, ack_b, tx, busy, owner;

  uart_tx_scheduler #(.DBIT(DBIT), .OVS(OVS), .SB_TICK(SB_TICK)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .rate    (rate),
    .req_a   (req_a),
    .data_a  (data_a),
    .ack_a   (ack_a),
    .req_b   (req_b),
    .data_b  (data_b),
    .ack_b   (ack_b),
    .tx      (tx),
    .busy    (busy),
    .owner   (owner)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Frame-level model: a frame is just a tick position 0..FRAME-1
  logic            m_busy = 1'b0;
  int              m_ticks = 0;
  logic [DBIT-1:0] m_data = '0;
  logic            m_owner = 1'b0;
  logic            m_last_b = 1'b1;
  logic            m_ack_a = 1'b0, m_ack_b = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_ticks <= 0; m_data <= '0; m_owner <= 1'b0;
      m_last_b <= 1'b1; m_ack_a <= 1'b0; m_ack_b <= 1'b0;
    end else begin
      m_ack_a <= 1'b0;
      m_ack_b <= 1'b0;
      if (!m_busy) begin
        if (req_b && (!req_a || !m_last_b)) begin
          m_busy <= 1'b1; m_ticks <= 0; m_data <= data_b;
          m_owner <= 1'b1; m_last_b <= 1'b1; m_ack_b <= 1'b1;
        end else if (req_a) begin
          m_busy <= 1'b1; m_ticks <= 0; m_data <= data_a;
          m_owner <= 1'b0; m_last_b <= 1'b0; m_ack_a <= 1'b1;
        end
      end else if (rate) begin
        if (m_ticks + 1 == FRAME) begin
          m_busy <= 1'b0; m_ticks <= 0;
        end else begin
          m_ticks <= m_ticks + 1;
        end
      end
    end
  end

  function automatic logic model_tx();
    if (!m_busy)                    return 1'b1;
    if (m_ticks < OVS)              return 1'b0;
    if (m_ticks < OVS * (1 + DBIT)) return m_data[m_ticks / OVS - 1];
    return 1'b1;
  endfunction

  always @(negedge clock) begin
    logic [4:0] got, exp;
    got = {tx, busy, owner, ack_a, ack_b};
    exp = {model_tx(), m_busy, m_owner, m_ack_a, m_ack_b};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model t=%0t {tx,busy,owner,ack_a,ack_b} got %b expected %b", $time, got, exp);
    end
  end

  // rmode: 0 no ticks, 1 one tick every 4 clocks, 2 tick every clock
  int rmode = 0;
  int rcnt  = 0;

  task automatic step();
    @(negedge clock);
    #1;
    case (rmode)
      0:       rate = 1'b0;
      1:       rate = (rcnt == 3);
      default: rate = 1'b1;
    endcase
    rcnt = (rcnt + 1) % 4;
  endtask

  initial begin
    logic [9:0] pat;
    int lows, highs_busy, nack_a, nack_b, first_ack_b, gap, last_ack, prev_busy;
    int seq_owner[4];

    // Reset state
    repeat (3) step();
    chk("rst_tx", tx, 1); chk("rst_busy", busy, 0); chk("rst_owner", owner, 0);
    chk("rst_ack_a", ack_a, 0); chk("rst_ack_b", ack_b, 0);

    // Single request 0x55, tick every 4 clocks, granted on first edge after release
    data_a = 8'h55; req_a = 1'b1; reset_n = 1'b1; rmode = 1; rcnt = 0; rate = 1'b0;
    pat = 10'b1010101010;
    for (int k = 1; k <= 650; k++) begin
      step();
      if (k == 1) begin chk("s_ack_a_c1", ack_a, 1); chk("s_ack_b_c1", ack_b, 0); req_a = 1'b0; end
      if (k == 2) chk("s_ack_a_c2", ack_a, 0);
      if ((k % 64) == 32 && (k / 64) < 10) chk($sformatf("s_bit%0d", k / 64), tx, pat[k / 64]);
      if (k == 640) chk("s_busy_640", busy, 1);
      if (k == 641) chk("s_busy_641", busy, 0);
    end

    // Continuous rate, 0x00: 144 low clocks then 16 high, idle at 161
    rmode = 2; rate = 1'b1; data_a = 8'h00; req_a = 1'b1;
    lows = 0; highs_busy = 0;
    for (int k = 1; k <= 170; k++) begin
      step();
      if (k == 1) begin chk("c_ack_a", ack_a, 1); req_a = 1'b0; end
      if (tx == 1'b0) lows++;
      if (busy == 1'b1) highs_busy++;
      if (k == 144) chk("c_tx_144", tx, 0);
      if (k == 145) chk("c_tx_145", tx, 1);
      if (k == 160) chk("c_busy_160", busy, 1);
      if (k == 161) chk("c_busy_161", busy, 0);
    end
    chk("c_low_clocks", lows, 144);
    chk("c_busy_clocks", highs_busy, 160);

    // Late request: B rises during A's DATA, served only after A's STOP
    data_a = 8'hC3; req_a = 1'b1; nack_a = 0; first_ack_b = 0;
    for (int k = 1; k <= 340; k++) begin
      step();
      if (k == 1) req_a = 1'b0;
      if (k == 40) begin data_b = 8'h3C; req_b = 1'b1; end
      if (ack_a) nack_a++;
      if (ack_b && first_ack_b == 0) begin first_ack_b = k; req_b = 1'b0; end
    end
    chk("l_ack_b_cycle", first_ack_b, 162);
    chk("l_ack_a_count", nack_a, 1);
    chk("l_idle_end", busy, 0);

    // Simultaneous requests held from reset: A1, B2, A1, B2
    reset_n = 1'b0;
    data_a = 8'hA1; data_b = 8'hB2; req_a = 1'b1; req_b = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    nack_a = 0; nack_b = 0;
    for (int k = 1; k <= 700 && (nack_a + nack_b) < 4; k++) begin
      step();
      if (ack_a || ack_b) begin
        seq_owner[nack_a + nack_b] = ack_b ? 1 : 0;
        if (ack_a) nack_a++; else nack_b++;
        if (owner !== ack_b) chk("r_owner_at_ack", owner, ack_b);
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("r_acks_total", nack_a + nack_b, 4);
    chk("r_order0", seq_owner[0], 0); chk("r_order1", seq_owner[1], 1);
    chk("r_order2", seq_owner[2], 0); chk("r_order3", seq_owner[3], 1);
    repeat (170) step();
    chk("r_idle_end", busy, 0);

    // Back-to-back: req_b held through 3 frames of 0xFF
    data_b = 8'hFF; req_b = 1'b1; nack_b = 0; gap = 0; last_ack = 0; prev_busy = 0;
    for (int k = 1; k <= 600; k++) begin
      step();
      if (ack_b) begin
        nack_b++;
        if (last_ack != 0) chk("b_ack_spacing", k - last_ack, FRAME + 1);
        last_ack = k;
        if (nack_b == 3) req_b = 1'b0;
      end
      if (nack_b >= 1 && nack_b < 3 && !busy) gap++;
      prev_busy = busy;
    end
    chk("b_ack_count", nack_b, 3);
    chk("b_idle_cycles", gap, 2);

    // Mid-frame reset during a B frame, then a fresh A frame
    data_b = 8'h0F; req_b = 1'b1;
    for (int k = 1; k <= 51; k++) begin
      step();
      if (k == 1) begin chk("m_owner_b", owner, 1); req_b = 1'b0; end
    end
    #1 reset_n = 1'b0;
    #1;
    chk("m_tx_async", tx, 1); chk("m_busy_async", busy, 0); chk("m_owner_async", owner, 0);
    data_a = 8'h5A; req_a = 1'b1;
    repeat (3) step();
    chk("m_no_ack_in_rst", ack_a, 0);
    reset_n = 1'b1;
    step();
    chk("m_ack_a", ack_a, 1); chk("m_owner_a", owner, 0); chk("m_busy", busy, 1);
    req_a = 1'b0;
    repeat (170) step();
    chk("m_idle_end", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
